// File: rtl/multicycle_cpu.sv
// Multi-cycle 32-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB FSM with busy-wait
// handshakes on instruction and data memories, bne, illegal-opcode halt and retire counter.
module multicycle_cpu #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [PC_W-1:0]   PC,
  output logic              IREAD,
  input  logic [31:0]       INSTRUCTION,
  input  logic              IBUSYWAIT,
  output logic              READ,
  output logic              WRITE,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              BUSYWAIT,
  output logic              HALTED,
  output logic [CNT_W-1:0]  RETIRED
);

  localparam int unsigned NREG = 1 << REG_AW;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_BNE   = 8'd12;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                ireq_q, ireq_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];

  // Instruction field decode from the latched IR
  logic [7:0]          op_c;
  logic [REG_AW-1:0]   dst_a_c;
  logic [REG_AW-1:0]   src1_a_c;
  logic [REG_AW-1:0]   src2_a_c;
  logic [DATA_W-1:0]   imm_c;
  logic [PC_W-1:0]     boff_c;
  logic                ir_unused_c;

  assign op_c        = ir_q[31:24];
  assign dst_a_c     = ir_q[16 +: REG_AW];
  assign src1_a_c    = ir_q[8 +: REG_AW];
  assign src2_a_c    = ir_q[0 +: REG_AW];
  assign imm_c       = DATA_W'(ir_q[7:0]);
  assign boff_c      = {{(PC_W-10){ir_q[23]}}, ir_q[23:16], 2'b00};
  assign ir_unused_c = ^ir_q[15:8+REG_AW];

  logic is_load_c, is_store_c, is_branch_c, is_jump_c, use_imm_c, illegal_c;

  assign is_load_c   = (op_c == OP_LWD) || (op_c == OP_LWI);
  assign is_store_c  = (op_c == OP_SWD) || (op_c == OP_SWI);
  assign is_branch_c = (op_c == OP_BEQ) || (op_c == OP_BNE);
  assign is_jump_c   = (op_c == OP_J);
  assign use_imm_c   = (op_c == OP_LOADI) || (op_c == OP_LWI) || (op_c == OP_SWI);
  assign illegal_c   = (op_c > OP_BNE);

  // ALU: two's-complement subtract doubles as the branch comparator
  logic [DATA_W-1:0] diff_c;
  logic [DATA_W-1:0] alu_c;
  logic              zero_c;
  logic              take_c;
  logic [PC_W-1:0]   pc_seq_c;

  assign diff_c   = opa_q + (~opb_q + DATA_W'(1));
  assign zero_c   = (diff_c == '0);
  assign take_c   = is_jump_c || ((op_c == OP_BEQ) && zero_c) || ((op_c == OP_BNE) && !zero_c);
  assign pc_seq_c = pc_q + PC_W'(4);

  always_comb begin
    alu_c = opb_q;
    case (op_c)
      OP_ADD:  alu_c = opa_q + opb_q;
      OP_SUB:  alu_c = diff_c;
      OP_AND:  alu_c = opa_q & opb_q;
      OP_OR:   alu_c = opa_q | opb_q;
      OP_MOV:  alu_c = opb_q;
      default: alu_c = opb_q;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    pc_d     = pc_q;
    ireq_d   = ireq_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    regs_d   = regs_q;

    unique case (state_q)
      S_FETCH: begin
        ireq_d = 1'b1;
        if (ireq_q && !IBUSYWAIT) begin
          ir_d    = INSTRUCTION;
          ireq_d  = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal_c) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          opa_d   = regs_q[src1_a_c];
          opb_d   = use_imm_c ? imm_c : regs_q[src2_a_c];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_jump_c || is_branch_c) begin
          pc_d    = take_c ? (pc_seq_c + boff_c) : pc_seq_c;
          cnt_d   = cnt_q + CNT_W'(1);
          ireq_d  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load_c || is_store_c) begin
          addr_d  = alu_c;
          wdata_d = opa_q;
          rd_d    = is_load_c;
          wr_d    = is_store_c;
          state_d = S_MEM;
        end else begin
          res_d   = alu_c;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_load_c) begin
          if (rd_q && !BUSYWAIT) begin
            res_d   = READDATA;
            rd_d    = 1'b0;
            state_d = S_WB;
          end
        end else if (wr_q && !BUSYWAIT) begin
          wr_d    = 1'b0;
          pc_d    = pc_seq_c;
          cnt_d   = cnt_q + CNT_W'(1);
          ireq_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        regs_d[dst_a_c] = res_q;
        pc_d            = pc_seq_c;
        cnt_d           = cnt_q + CNT_W'(1);
        ireq_d          = 1'b1;
        state_d         = S_FETCH;
      end
      S_HALT: begin
        ireq_d = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
      end
      default: begin
        halted_d = 1'b1;
        state_d  = S_HALT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      pc_q     <= '0;
      ireq_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      pc_q     <= pc_d;
      ireq_q   <= ireq_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      regs_q   <= regs_d;
    end
  end

  assign PC        = pc_q;
  assign IREAD     = ireq_q;
  assign READ      = rd_q;
  assign WRITE     = wr_q;
  assign ADDRESS   = addr_q;
  assign WRITEDATA = wdata_q;
  assign HALTED    = halted_q;
  assign RETIRED   = cnt_q;

endmodule
